// File: rtl/uart_mem_loader.sv
// UART byte-stream loader: SYNC, COUNT, then COUNT big-endian words into memory.
// Holds the CPU in reset while a frame is being loaded or after a broken frame.
module uart_mem_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  MemWrite_en,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  load_done,
    output logic                  err
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW        = ADDR_WIDTH + 1;
    localparam logic [8:0]  DEPTH9    = 9'(RAM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_DONE,
        S_ERR
    } state_e;

    state_e                state_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         word_idx_q;
    logic [CW-1:0]         word_idx_d;
    logic [1:0]            byte_cnt_q;
    logic [DATA_WIDTH-9:0] shift_q;
    logic [DATA_WIDTH-9:0] shift_d;
    logic [DATA_WIDTH-1:0] word_d;
    logic [TW-1:0]         tmo_q;
    logic [TW-1:0]         tmo_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  cpu_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic is_sync;
    logic count_bad;
    logic tmo_hit;
    logic all_issued;

    // Only three bytes need holding; the fourth comes straight from rx_data.
    assign shift_d    = {shift_q[DATA_WIDTH-17:0], rx_data};
    assign word_d     = {shift_q, rx_data};
    assign word_idx_d = word_idx_q + CW'(1);
    assign tmo_d      = tmo_q + TW'(1);

    assign is_sync    = rx_valid && (rx_data == SYNC_BYTE);
    assign count_bad  = (rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH9);
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign all_issued = (word_idx_q == count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cpu_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cpu_q <= 1'b1;
                    tmo_q <= '0;
                    if (is_sync) begin
                        state_q <= S_COUNT;
                        cpu_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (rx_valid) begin
                        tmo_q <= '0;
                        if (count_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= S_DATA;
                            count_q    <= CW'(rx_data);
                            word_idx_q <= '0;
                            byte_cnt_q <= '0;
                        end
                    end else if (tmo_hit) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_DATA: begin
                    // The last write is in flight; no more bytes belong to this frame.
                    if (all_issued) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        tmo_q   <= '0;
                    end else if (rx_valid) begin
                        tmo_q      <= '0;
                        shift_q    <= shift_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_q       <= 1'b1;
                            addr_q     <= word_idx_q[ADDR_WIDTH-1:0];
                            wdata_q    <= word_d;
                            word_idx_q <= word_idx_d;
                        end
                    end else if (tmo_hit) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_DONE: begin
                    cpu_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    if (is_sync) begin
                        state_q <= S_COUNT;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Address     = addr_q;
    assign WriteData   = wdata_q;
    assign MemWrite_en = we_q;
    assign cpu_rst_n   = cpu_q;
    assign busy        = busy_q;
    assign load_done   = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: frame-level reference model compared every cycle,
// plus directed frames with literal expectations and randomized frames.
module tb_uart_mem_loader;

    localparam int          AW = 4;
    localparam int          TO = 100;
    localparam logic [7:0]  SY = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic [AW-1:0]   Address;
    logic [31:0]     WriteData;
    logic            MemWrite_en;
    logic            cpu_rst_n;
    logic            busy;
    logic            load_done;
    logic            err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (AW),
        .SYNC_BYTE     (SY),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemWrite_en(MemWrite_en),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .load_done  (load_done),
        .err        (err)
    );

    // Reference model: phase 0 idle, 1 count, 2 data, 3 done, 4 error
    int          ph;
    int          total;
    int          written;
    int          idle_n;
    bit          tail;
    logic [7:0]  wq[$];
    logic [AW-1:0] e_addr;
    logic [31:0] e_wdata;
    bit          e_we, e_cpu, e_busy, e_done, e_err;

    task automatic m_reset();
        ph = 0; total = 0; written = 0; idle_n = 0; tail = 0;
        wq.delete();
        e_addr = '0; e_wdata = '0;
        e_we = 0; e_cpu = 0; e_busy = 0; e_done = 0; e_err = 0;
    endtask

    task automatic m_step(input bit v, input logic [7:0] b);
        e_we = 0;
        e_done = 0;
        case (ph)
            0: begin
                if (v && b == SY) begin
                    ph = 1; idle_n = 0; e_cpu = 0;
                end else begin
                    e_cpu = 1;
                end
            end
            1: begin
                if (v) begin
                    idle_n = 0;
                    if (b == 0 || b > (1 << AW)) begin
                        ph = 4; e_err = 1;
                    end else begin
                        ph = 2; total = b; written = 0; tail = 0;
                        wq.delete();
                    end
                end else begin
                    idle_n++;
                    if (idle_n >= TO) begin ph = 4; e_err = 1; end
                end
            end
            2: begin
                if (tail) begin
                    ph = 3; e_done = 1;
                end else if (v) begin
                    idle_n = 0;
                    wq.push_back(b);
                    if (wq.size() == 4) begin
                        e_we = 1;
                        e_addr = AW'(written);
                        e_wdata = {wq[0], wq[1], wq[2], wq[3]};
                        written++;
                        wq.delete();
                        if (written == total) tail = 1;
                    end
                end else begin
                    idle_n++;
                    if (idle_n >= TO) begin ph = 4; e_err = 1; end
                end
            end
            3: begin
                ph = 0; e_cpu = 1;
            end
            default: begin
                if (v && b == SY) begin
                    ph = 1; idle_n = 0; e_err = 0;
                end
            end
        endcase
        e_busy = (ph == 1 || ph == 2);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step(rx_valid, rx_data);
        end
    end

    logic [35:0] wlog[$];
    int          ndone = 0;

    initial begin
        forever begin
            @(negedge clk);
            tests++;
            if ({Address, WriteData, MemWrite_en, cpu_rst_n, busy, load_done, err} !==
                {e_addr, e_wdata, e_we, e_cpu, e_busy, e_done, e_err}) begin
                fails++;
                $display("FAIL cycle t=%0t: got A=%0h D=%08h we=%b cpu=%b busy=%b done=%b err=%b want A=%0h D=%08h we=%b cpu=%b busy=%b done=%b err=%b",
                    $time, Address, WriteData, MemWrite_en, cpu_rst_n, busy, load_done, err,
                    e_addr, e_wdata, e_we, e_cpu, e_busy, e_done, e_err);
            end
            if (MemWrite_en === 1'b1) wlog.push_back({Address, WriteData});
            if (load_done === 1'b1) ndone++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data = v ? b : 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 8'h00);
    endtask

    task automatic send(input bq_t q, input int maxgap);
        foreach (q[i]) begin
            cyc(1, q[i]);
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) cyc(0, 8'h00);
        end
        cyc(0, 8'h00);
    endtask

    task automatic clr();
        wlog.delete();
        ndone = 0;
    endtask

    initial begin
        bq_t q;
        // reset
        repeat (2) @(posedge clk);
        #2;
        chk("reset cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        chk("cpu runs after release", 64'(cpu_rst_n), 64'd1);

        // 1 normal
        clr();
        q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send(q, 0);
        idle(5);
        chk("t1 writes", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("t1 word0", 64'(wlog[0]), 64'({4'h0, 32'h0000_0001}));
            chk("t1 word1", 64'(wlog[1]), 64'({4'h1, 32'hDEAD_BEEF}));
        end
        chk("t1 load_done", 64'(ndone), 64'd1);
        chk("t1 cpu_rst_n", 64'(cpu_rst_n), 64'd1);

        // 2 noise before sync
        clr();
        q = '{8'h12, 8'h34, 8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        send(q, 2);
        idle(5);
        chk("t2 writes", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("t2 word0", 64'(wlog[0]), 64'({4'h0, 32'hA5A5_A5A5}));

        // 3 bad counts
        clr();
        q = '{8'hA5, 8'h00};
        send(q, 1);
        idle(3);
        chk("t3 err zero count", 64'(err), 64'd1);
        q = '{8'hA5, 8'h11};
        send(q, 0);
        idle(3);
        chk("t3 err count 17", 64'(err), 64'd1);
        chk("t3 cpu held", 64'(cpu_rst_n), 64'd0);
        chk("t3 no writes", 64'(wlog.size()), 64'd0);

        // 4 timeout and recovery
        clr();
        q = '{8'hA5, 8'h01, 8'hAA, 8'hBB};
        send(q, 0);
        idle(99);
        chk("t4 no err at 99", 64'(err), 64'd0);
        idle(1);
        chk("t4 err at 100", 64'(err), 64'd1);
        chk("t4 busy dropped", 64'(busy), 64'd0);
        q = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send(q, 0);
        idle(5);
        chk("t4 err cleared", 64'(err), 64'd0);
        chk("t4 writes", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("t4 word0", 64'(wlog[0]), 64'({4'h0, 32'h1122_3344}));
        chk("t4 cpu released", 64'(cpu_rst_n), 64'd1);

        // byte arriving on the timeout cycle is kept
        clr();
        cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'hAA);
        idle(99);
        cyc(1, 8'hBB); cyc(1, 8'hCC); cyc(1, 8'hDD);
        idle(5);
        chk("t4b err", 64'(err), 64'd0);
        if (wlog.size() == 1) chk("t4b word0", 64'(wlog[0]), 64'({4'h0, 32'hAABB_CCDD}));
        else chk("t4b writes", 64'(wlog.size()), 64'd1);

        // 5 reset mid-word
        clr();
        cyc(1, 8'hA5); cyc(1, 8'h02); cyc(1, 8'h01); cyc(1, 8'h02);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #2;
        chk("t5 WriteData reset", 64'(WriteData), 64'd0);
        chk("t5 busy reset", 64'(busy), 64'd0);
        chk("t5 cpu reset", 64'(cpu_rst_n), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        q = '{8'hA5, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h23, 8'h45, 8'h67};
        send(q, 1);
        idle(5);
        chk("t5 writes", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("t5 word0", 64'(wlog[0]), 64'({4'h0, 32'hCAFE_BABE}));
            chk("t5 word1", 64'(wlog[1]), 64'({4'h1, 32'h0123_4567}));
        end

        // 6 full depth, back-to-back
        clr();
        q = '{8'hA5, 8'h10};
        for (int k = 0; k < 64; k++) q.push_back(8'(k));
        send(q, 0);
        idle(5);
        chk("t6 writes", 64'(wlog.size()), 64'd16);
        if (wlog.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("t6 word%0d", i), 64'(wlog[i]),
                    64'({4'(i), 8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}));
            end
        end
        chk("t6 load_done", 64'(ndone), 64'd1);

        // 7 randomized frames
        for (int f = 0; f < 40; f++) begin
            int r;
            int cnt;
            int nb;
            q = {};
            repeat ($urandom_range(2, 0)) q.push_back(8'($urandom));
            q.push_back(SY);
            r = $urandom_range(9, 0);
            if (r == 0) cnt = 0;
            else if (r == 1) cnt = $urandom_range(255, 17);
            else cnt = $urandom_range(16, 1);
            q.push_back(8'(cnt));
            nb = (cnt >= 1 && cnt <= 16) ? 4 * cnt : $urandom_range(3, 0);
            if ($urandom_range(4, 0) == 0 && nb > 0) nb = $urandom_range(nb - 1, 0);
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(7, 0) == 0) q.push_back(SY);
                else q.push_back(8'($urandom));
            end
            send(q, $urandom_range(3, 0));
            idle($urandom_range(1, 0) == 0 ? $urandom_range(4, 0) : $urandom_range(105, 98));
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
